regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 8x8 two-read register file used by the single-cycle core.
- Generalises data width, register count and number of read ports.
- Adds synchronous active-low clear, a hardwired-zero R0 and optional write-to-read bypass.
- Adds a per-register pending (scoreboard) bit with reserve/release semantics and a live count of pending registers, so a pipelined core can detect RAW hazards.

Parameters:
DATA_WIDTH, 8, bits per register
ADDR_WIDTH, 3, register index width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of independent read ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads show stored value only

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
rd_addr  in  NUM_READ*ADDR_WIDTH  read indices; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_READ*DATA_WIDTH  read data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
rd_busy  out  NUM_READ  1 = register addressed by port k has a pending write
wr_en  in  1  write strobe; also releases pending bit of wr_addr
wr_addr  in  ADDR_WIDTH  write index
wr_data  in  DATA_WIDTH  write data
rsv_en  in  1  reserve strobe; marks rsv_addr pending
rsv_addr  in  ADDR_WIDTH  index to reserve
pend_cnt  out  ADDR_WIDTH+1  number of registers currently pending

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset: when rst_n=0 at a rising edge, all registers and all pending bits clear to 0 and pend_cnt becomes 0. Reset overrides wr_en and rsv_en in that cycle.
- Outputs after reset: rd_data = 0 for every port unless a bypass applies; rd_busy = 0; pend_cnt = 0.
- Storage: reg[i] for i = 0 .. 2**ADDR_WIDTH-1.
  - reg[0] reads as 0 always.
  - Writes and reservations to index 0 are ignored: no data change, no pending bit, no count change.
- Write: if wr_en=1 and wr_addr!=0 at a rising edge, reg[wr_addr] <= wr_data. The stored value is visible from the next cycle.
- Read is combinational, zero latency, per port k with a = rd_addr[k]:
  - if a==0: rd_data[k] = 0;
  - else if BYPASS=1 and wr_en=1 and wr_addr==a: rd_data[k] = wr_data;
  - else: rd_data[k] = reg[a].
- Multiple read ports addressing the same register return identical data.
- Scoreboard, evaluated at each rising edge with rst_n=1:
  - set = rsv_en & (rsv_addr!=0); clr = wr_en & (wr_addr!=0).
  - set and clr on different indices: pend[rsv_addr] <= 1, pend[wr_addr] <= 0.
  - set and clr on the same index: pend stays 1. The write lands, but the new reservation wins.
  - Reserving an already-pending index: no change; pend_cnt not incremented.
  - Writing a non-pending index: data written, pend unchanged, pend_cnt not decremented.
- pend_cnt is a registered counter equal to popcount(pend) at all times.
  - Updated in the same edge as pend, by -1, 0 or +1 according to the actual bit transitions.
  - Range 0 .. 2**ADDR_WIDTH-1; never wraps.
- rd_busy[k] = pend[a] & ~(BYPASS & wr_en & wr_addr==a), with a = rd_addr[k].
  - A same-cycle reserve does not affect the current cycle's rd_busy.
  - rd_busy[k] = 0 when a==0.
- No X propagation: every register is defined after the first reset edge.
- Implementation target: 120-400 lines of RTL, no latches, reads as pure combinational logic.

Test Plan:
- Reset clear: write 8'hA5 to r3, then rst_n=0 for one edge → rd_data(r3)=0, pend_cnt=0, rd_busy=0. Repeat with wr_en=1 and rsv_en=1 asserted during the reset cycle → still all zero.
- R0 hardwired: wr_en=1, wr_addr=0, wr_data=8'hFF, rsv_en=1, rsv_addr=0 → rd_data(r0)=0, rd_busy=0, pend_cnt=0.
- Bypass, BYPASS=1: r5=8'h11 stored; drive wr_en=1, wr_addr=5, wr_data=8'h22 with port0 and port1 both reading r5 → both show 8'h22 in the same cycle. With BYPASS=0, same stimulus → 8'h11 that cycle, 8'h22 next cycle.
- Reserve/release: reserve r2, then r6 → pend_cnt=2, rd_busy(r2)=1. Write r2 → pend_cnt=1, and rd_busy(r2)=0 in the write cycle (BYPASS=1). Reserve r6 again → pend_cnt stays 1.
- Simultaneous reserve+write same index: r4 pending; rsv_en=1, rsv_addr=4, wr_en=1, wr_addr=4, wr_data=8'h3C → next cycle reg[4]=8'h3C, rd_busy(r4)=1, pend_cnt unchanged.
- Full scoreboard and width: ADDR_WIDTH=3, reserve r1..r7 → pend_cnt=7. Write all seven → pend_cnt=0. Rerun with DATA_WIDTH=16, NUM_READ=3, writing 16'hBEEF to r7 → all three ports reading r7 return 16'hBEEF.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised multi-read register file with hardwired-zero R0, optional
// write-to-read bypass and a per-register pending scoreboard for RAW hazards.
module regfile_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  output logic [ADDR_WIDTH:0]            pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      pend_nxt;
  logic [ADDR_WIDTH:0]   cnt;

  logic set_req;
  logic clr_req;
  logic cnt_up;
  logic cnt_dn;

  // Moves the pending count by the net bit transition, so it never wraps.
  function automatic logic [ADDR_WIDTH:0] cnt_step(
    input logic [ADDR_WIDTH:0] c,
    input logic                up,
    input logic                dn
  );
    logic [ADDR_WIDTH:0] r;
    r = c;
    if (up && !dn)
      r = c + CNT_ONE;
    else if (dn && !up)
      r = c - CNT_ONE;
    return r;
  endfunction

  assign set_req = rsv_en && (rsv_addr != '0);
  assign clr_req = wr_en && (wr_addr != '0);

  // A reservation on the same index as a write wins, so no decrement then.
  assign cnt_up = set_req && !pend[rsv_addr];
  assign cnt_dn = clr_req && pend[wr_addr] && !(set_req && (rsv_addr == wr_addr));

  always_comb begin
    pend_nxt = pend;
    if (clr_req)
      pend_nxt[wr_addr] = 1'b0;
    if (set_req)
      pend_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (clr_req) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_step(cnt, cnt_up, cnt_dn);
    end
  end

  assign pend_cnt = cnt;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic                  byp;

    assign a   = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign byp = (BYPASS != 0) && wr_en && (wr_addr == a);

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = (a == '0) ? '0 :
                                                 byp        ? wr_data :
                                                              regs[a];
    assign rd_busy[k] = (a != '0) && pend[a] && !byp;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypassing default, non-bypassing and a wide
// three-port instance all see the same write/reserve stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  rd_addr3;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data16;
  logic        rsv_en;
  logic [2:0]  rsv_addr;

  logic [15:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [3:0]  pend_cnt_a;
  logic [15:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [3:0]  pend_cnt_b;
  logic [47:0] rd_data_c;
  logic [2:0]  rd_busy_c;
  logic [3:0]  pend_cnt_c;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_READ(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr3[5:0]), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data16[7:0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt_a)
  );

  regfile_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_READ(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr3[5:0]), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data16[7:0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt_b)
  );

  regfile_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(3), .BYPASS(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr3), .rd_data(rd_data_c),
    .rd_busy(rd_busy_c), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data16),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic rd_ports(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    rd_addr3 = {a2, a1, a0};
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr3 = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data16 = '0; rsv_en = 1'b0; rsv_addr = '0;
    tick();
    rst_n = 1'b1;
    rd_ports(3'd3, 3'd3, 3'd3);
    check("rst_data", 32'(rd_data_a), 32'h0);
    check("rst_busy", 32'(rd_busy_a), 32'h0);
    check("rst_cnt", 32'(pend_cnt_a), 32'h0);

    // Reset clear, including a reset edge that also sees write and reserve
    wr_en = 1'b1; wr_addr = 3'd3; wr_data16 = 16'h00A5;
    tick();
    idle();
    rd_ports(3'd3, 3'd3, 3'd3);
    check("wr_r3", 32'(rd_data_a[7:0]), 32'hA5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_clr_r3", 32'(rd_data_a[7:0]), 32'h0);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data16 = 16'h0077;
    rsv_en = 1'b1; rsv_addr = 3'd3; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    check("rst_ovr_data", 32'(rd_data_a), 32'h0);
    check("rst_ovr_busy", 32'(rd_busy_a), 32'h0);
    check("rst_ovr_cnt", 32'(pend_cnt_a), 32'h0);

    // R0 hardwired
    wr_en = 1'b1; wr_addr = 3'd0; wr_data16 = 16'h00FF;
    rsv_en = 1'b1; rsv_addr = 3'd0;
    rd_ports(3'd0, 3'd0, 3'd0);
    check("r0_byp_data", 32'(rd_data_a), 32'h0);
    tick();
    idle();
    #1;
    check("r0_data", 32'(rd_data_a), 32'h0);
    check("r0_busy", 32'(rd_busy_a), 32'h0);
    check("r0_cnt", 32'(pend_cnt_a), 32'h0);

    // Bypass versus stored-only reads
    wr_en = 1'b1; wr_addr = 3'd5; wr_data16 = 16'h0011;
    tick();
    wr_data16 = 16'h0022;
    rd_ports(3'd5, 3'd5, 3'd5);
    check("byp_p0", 32'(rd_data_a[7:0]), 32'h22);
    check("byp_p1", 32'(rd_data_a[15:8]), 32'h22);
    check("nobyp_p0", 32'(rd_data_b[7:0]), 32'h11);
    check("nobyp_p1", 32'(rd_data_b[15:8]), 32'h11);
    tick();
    idle();
    #1;
    check("nobyp_next", 32'(rd_data_b[7:0]), 32'h22);
    check("byp_next", 32'(rd_data_a[7:0]), 32'h22);

    // Reserve / release
    rsv_en = 1'b1; rsv_addr = 3'd2;
    tick();
    rsv_addr = 3'd6;
    tick();
    idle();
    rd_ports(3'd2, 3'd6, 3'd0);
    check("rsv_cnt2", 32'(pend_cnt_a), 32'd2);
    check("rsv_busy", 32'(rd_busy_a), 32'b11);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data16 = 16'h005A;
    #1;
    check("rel_busy_byp", 32'(rd_busy_a), 32'b10);
    check("rel_busy_nobyp", 32'(rd_busy_b), 32'b11);
    tick();
    idle();
    #1;
    check("rel_cnt1", 32'(pend_cnt_a), 32'd1);
    check("rel_busy_after", 32'(rd_busy_b), 32'b10);
    rsv_en = 1'b1; rsv_addr = 3'd6;
    tick();
    idle();
    #1;
    check("rersv_cnt", 32'(pend_cnt_a), 32'd1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data16 = 16'h0033;
    tick();
    idle();
    #1;
    check("wr_nonpend_cnt", 32'(pend_cnt_a), 32'd1);

    // Simultaneous reserve and write on the same index
    rsv_en = 1'b1; rsv_addr = 3'd4;
    tick();
    idle();
    #1;
    check("r4_cnt", 32'(pend_cnt_a), 32'd2);
    rsv_en = 1'b1; rsv_addr = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data16 = 16'h003C;
    tick();
    idle();
    rd_ports(3'd4, 3'd0, 3'd0);
    check("same_data", 32'(rd_data_a[7:0]), 32'h3C);
    check("same_busy", 32'(rd_busy_a[0]), 32'h1);
    check("same_cnt", 32'(pend_cnt_a), 32'd2);

    // Full scoreboard, then drain, on all three instances
    for (int i = 1; i < 8; i++) begin
      rsv_en = 1'b1; rsv_addr = 3'(i);
      tick();
    end
    idle();
    #1;
    check("full_cnt_a", 32'(pend_cnt_a), 32'd7);
    check("full_cnt_b", 32'(pend_cnt_b), 32'd7);
    check("full_cnt_c", 32'(pend_cnt_c), 32'd7);
    for (int i = 1; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i);
      wr_data16 = (i == 7) ? 16'hBEEF : 16'(i);
      tick();
    end
    idle();
    rd_ports(3'd7, 3'd7, 3'd7);
    check("drain_cnt_a", 32'(pend_cnt_a), 32'd0);
    check("drain_cnt_c", 32'(pend_cnt_c), 32'd0);
    check("wide_p0", 32'(rd_data_c[15:0]), 32'hBEEF);
    check("wide_p1", 32'(rd_data_c[31:16]), 32'hBEEF);
    check("wide_p2", 32'(rd_data_c[47:32]), 32'hBEEF);
    check("wide_busy", 32'(rd_busy_c), 32'h0);
    check("narrow_r7", 32'(rd_data_a[7:0]), 32'hEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
